// File: rtl/interrupt_controller_if.sv
// Handshake bundle between the interrupt controller and the control unit / I/O side.
// IRQ_MASK_EN adds the mask write port to the bundle.
interface interrupt_controller_if #(
   parameter int N_IRQ = 4,
   parameter int PC_W  = 32
);
   logic [N_IRQ-1:0] irq;
   logic             inta;
   logic             clearIntr;
   logic             userMode;
   logic             kernelMode;
   logic [PC_W-1:0]  pc;
   logic             intr;
   logic [31:0]      intrCode;
   logic [PC_W-1:0]  intrPc;
   logic             inService;
`ifdef IRQ_MASK_EN
   logic             maskWrite;
   logic [N_IRQ:0]   maskData;

   modport master (
      output irq, inta, clearIntr, userMode, kernelMode, pc, maskWrite, maskData,
      input  intr, intrCode, intrPc, inService
   );
   modport slave (
      input  irq, inta, clearIntr, userMode, kernelMode, pc, maskWrite, maskData,
      output intr, intrCode, intrPc, inService
   );
`else
   modport master (
      output irq, inta, clearIntr, userMode, kernelMode, pc,
      input  intr, intrCode, intrPc, inService
   );
   modport slave (
      input  irq, inta, clearIntr, userMode, kernelMode, pc,
      output intr, intrCode, intrPc, inService
   );
`endif
endinterface

// File: rtl/interrupt_controller.sv
// Interrupt responder: pending irq/timer sources, user-mode gating, inta acceptance.
// Optional IRQ_MASK_EN adds a per-source enable mask (reset all enabled).
module interrupt_controller #(
   parameter int N_IRQ   = 4,
   parameter int QUANTUM = 1000,
   parameter int PC_W    = 32,
   parameter int SW_CODE = 15
) (
   input logic                  clk,
   input logic                  rst,
   interrupt_controller_if.slave bus
);
   localparam int PW = N_IRQ + 1;
   localparam int TW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

   typedef enum logic {IDLE, SERVICE} stateT;

   stateT            r_state, w_stateNext;
   logic [PW-1:0]    r_pending, w_pendingNext;
   logic [N_IRQ-1:0] r_irqPrev;
   logic             r_user, w_userNext;
   logic [TW-1:0]    r_timer, w_timerNext;
   logic             r_intr, w_intrNext;
   logic [31:0]      r_intrCode, w_intrCodeNext;
   logic [PC_W-1:0]  r_intrPc, w_intrPcNext;
   logic [PW-1:0]    w_mask, w_active, w_set, w_clear, w_selOneHot;
   logic [N_IRQ-1:0] w_irqRise;
   logic [31:0]      w_selCode;
   logic             w_accept, w_swReq, w_timerTick, w_timerWrap;

`ifdef IRQ_MASK_EN
   logic [PW-1:0] r_mask;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)               r_mask <= '1;
      else if (bus.maskWrite) r_mask <= bus.maskData;
   end
   assign w_mask = r_mask;
`else
   assign w_mask = '1;
`endif

   assign w_active    = r_pending & w_mask;
   assign w_irqRise   = bus.irq & ~r_irqPrev;
   assign w_timerTick = r_user && (r_state == IDLE) && !bus.userMode;
   assign w_timerWrap = w_timerTick && (r_timer == TW'(QUANTUM - 1));
   assign w_set       = {w_irqRise, w_timerWrap};

   // Lowest index wins, so the scan runs downward and the last hit sticks.
   always_comb begin
      w_selOneHot = '0;
      w_selCode   = '0;
      for (int i = PW - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            w_selOneHot    = '0;
            w_selOneHot[i] = 1'b1;
            w_selCode      = 32'(i + 1);
         end
      end
   end

   assign w_accept      = (r_state == IDLE) && bus.inta && r_intr && (|w_active);
   assign w_swReq       = (r_state == IDLE) && bus.inta && !w_accept;
   assign w_clear       = w_accept ? w_selOneHot : '0;
   assign w_pendingNext = (r_pending & ~w_clear) | w_set;

   always_comb begin
      w_userNext = r_user;
      if (bus.userMode)                w_userNext = 1'b1;
      if (bus.kernelMode || w_accept)  w_userNext = 1'b0;
   end

   always_comb begin
      w_timerNext = r_timer;
      if (bus.userMode)      w_timerNext = '0;
      else if (w_timerWrap)  w_timerNext = '0;
      else if (w_timerTick)  w_timerNext = r_timer + 1'b1;
   end

   // intr stays low through SERVICE and on the cycle a request is taken.
   always_comb begin
      w_stateNext    = r_state;
      w_intrNext     = 1'b0;
      w_intrCodeNext = r_intrCode;
      w_intrPcNext   = r_intrPc;
      case (r_state)
         IDLE: begin
            if (bus.clearIntr) w_intrCodeNext = '0;
            if (w_accept) begin
               w_intrCodeNext = w_selCode;
               w_intrPcNext   = bus.pc;
               w_stateNext    = SERVICE;
            end else if (w_swReq) begin
               w_intrCodeNext = 32'(SW_CODE);
               w_intrPcNext   = bus.pc;
               w_stateNext    = SERVICE;
            end else begin
               w_intrNext = r_user & (|w_active);
            end
         end
         SERVICE: begin
            if (bus.clearIntr) begin
               w_intrCodeNext = '0;
               w_stateNext    = IDLE;
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_pending  <= '0;
         r_irqPrev  <= '0;
         r_user     <= 1'b0;
         r_timer    <= '0;
         r_intr     <= 1'b0;
         r_intrCode <= '0;
         r_intrPc   <= '0;
      end else begin
         r_state    <= w_stateNext;
         r_pending  <= w_pendingNext;
         r_irqPrev  <= bus.irq;
         r_user     <= w_userNext;
         r_timer    <= w_timerNext;
         r_intr     <= w_intrNext;
         r_intrCode <= w_intrCodeNext;
         r_intrPc   <= w_intrPcNext;
      end
   end

   assign bus.intr      = r_intr;
   assign bus.intrCode  = r_intrCode;
   assign bus.intrPc    = r_intrPc;
   assign bus.inService = (r_state == SERVICE);

endmodule
